// File: rtl/receive_if.sv
// Serial receive bus: the line into the receiver plus its byte/error outputs.
// The master drives din; the slave (the receiver) produces the results.
interface receive_if;
    logic       din;
    logic       din_vld;
    logic [7:0] din_data;
    logic       frame_err;

    modport master (
        output din,
        input  din_vld,
        input  din_data,
        input  frame_err
    );

    modport slave (
        input  din,
        output din_vld,
        output din_data,
        output frame_err
    );
endinterface

// File: rtl/receive.sv
// 8N1 UART receiver with mid-bit sampling, framing-error reporting and break handling.
// Define RX_SYNC_EN to pass din through a two-flop synchronizer (adds 2 cycles of latency).
module receive #(
    parameter int FULL_T = 867,
    parameter int HALF_T = 433
) (
    input logic       clk,
    input logic       rst,
    receive_if.slave  bus
);
    localparam int MAX_T = (FULL_T > HALF_T) ? FULL_T : HALF_T;
    localparam int CW    = (MAX_T < 2) ? 1 : $clog2(MAX_T + 1);
    localparam logic [CW-1:0] FULL_C = CW'(FULL_T);
    localparam logic [CW-1:0] HALF_C = CW'(HALF_T);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        r_state;
    logic [CW-1:0] r_div_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_vld;
    logic          r_err;
    logic          w_line;

`ifdef RX_SYNC_EN
    logic r_sync0;
    logic r_sync1;

    // Flops reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= bus.din;
            r_sync1 <= r_sync0;
        end
    end

    assign w_line = r_sync1;
`else
    assign w_line = bus.din;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_line) begin
                        r_state   <= START;
                        r_div_cnt <= '0;
                    end
                end
                START: begin
                    if (r_div_cnt == HALF_C) begin
                        if (w_line) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_div_cnt <= '0;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_div_cnt == FULL_C) begin
                        r_div_cnt          <= '0;
                        r_shift[r_bit_cnt] <= w_line;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_div_cnt == FULL_C) begin
                        r_div_cnt <= '0;
                        if (w_line) begin
                            r_data  <= r_shift;
                            r_vld   <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    // A held-low line is one long break, not a stream of bad frames.
                    if (w_line) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.din_vld   = r_vld;
    assign bus.din_data  = r_data;
    assign bus.frame_err = r_err;
endmodule
